m_shiftseq: RTL
===============

M_SHIFTSEQ -- requirements
Module: m_shiftseq

Interface
REQ-001 SHALL have parameter: none; all behaviour is fixed or selected by the Configuration macro.
REQ-002 SHALL have ports: clk  in  1  system clock, rising edge; sole clock.
REQ-003 SHALL have ports: rstn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: start  in  1  request one shift operation; sampled in IDLE only.
REQ-005 SHALL have ports: op  in  2  00 SLL, 01 SRL, 11 SRA, 10 reserved (treated as SRL).
REQ-006 SHALL have ports: byteop  in  1  byte-lane shift request (see Configuration).
REQ-007 SHALL have ports: A  in  32  operand to shift; sampled with start.
REQ-008 SHALL have ports: lastshift  in  1  from the shift counter, high when the counter is at zero while s_shift[1]=1.
REQ-009 SHALL have ports: s_shift  out  2  shift counter operation: 00 load B, 01 load B[1:0]*8, 10 count down, 11 hold.
REQ-010 SHALL have ports: Q  out  32  shift result register.
REQ-011 SHALL have ports: busy  out  1  operation in progress.
REQ-012 SHALL have ports: done  out  1  one-cycle pulse, Q valid.

Function
REQ-013 SHALL implement states IDLE, LOAD, SHIFT, DONE.
REQ-014 IDLE: s_shift=11, busy=0; start=1 -> latch A into Q, latch op, go LOAD next cycle.
REQ-015 LOAD (one cycle): s_shift=00 (or 01 per REQ-026), busy=1, Q unchanged; go SHIFT.
REQ-016 SHIFT: s_shift=10, busy=1; lastshift=0 -> Q shifted by one bit, stay SHIFT; lastshift=1 -> Q unchanged, go DONE.
REQ-017 Shift step: SLL Q<={Q[30:0],0}; SRL Q<={0,Q[31:1]}; SRA Q<={Q[31],Q[31:1]}.
REQ-018 Number of shift steps SHALL equal the counter load value N (0..31); cycles from start to done = N+3.
REQ-019 N=0: first SHIFT cycle sees lastshift=1; zero steps; Q=A at done.
REQ-020 DONE (one cycle): s_shift=11, busy=0, done=1; go IDLE; start in DONE ignored.
REQ-021 start SHALL be ignored while busy=1 or done=1; no queuing.
REQ-022 lastshift SHALL be ignored outside SHIFT.
REQ-023 Q SHALL hold its value in IDLE and DONE until the next accepted start.

Reset
REQ-024 rstn=0 SHALL force, asynchronously, state IDLE, Q=0, latched op=00, done=0, busy=0, s_shift=11.
REQ-025 Reset asserted mid-operation SHALL abort it; no done pulse follows; first start after release behaves as from power-up.

Configuration
REQ-026 Macro SHIFTSEQ_BYTESTEP_EN defined: byteop latched with start; byteop=1 -> LOAD drives s_shift=01 (N=B[1:0]*8), else 00.
REQ-027 Macro SHIFTSEQ_BYTESTEP_EN undefined: byteop ignored, LOAD always drives s_shift=00; no byteop storage.

Verification
REQ-028 Bench SHALL pair the block with the shift counter, counter B driven by bench, for all scenarios.
REQ-029 start, op=00, A=0x0000_0001, B=5 -> s_shift 00 then 10 x6 then 11; done at cycle 8; Q=0x0000_0020.
REQ-030 start, op=11, A=0x8000_0000, B=31 -> done at cycle 34; Q=0xFFFF_FFFF; op=01 same input -> Q=0x0000_0001.
REQ-031 start, op=01, A=0xDEAD_BEEF, B=0 -> done at cycle 3; Q=0xDEAD_BEEF; start pulsed during busy and in DONE -> ignored.
REQ-032 rstn low in SHIFT after 2 steps (B=10) -> Q=0, busy=0, s_shift=11 immediately, no done; next start, B=1, A=0x2, op=01 -> Q=0x1.
REQ-033 SHIFTSEQ_BYTESTEP_EN defined, byteop=1, op=01, B=0x2, A=0x1234_5678 -> s_shift=01 in LOAD, 16 steps, Q=0x0000_1234; undefined -> 2 steps, Q=0x048D_159E.

Source files
------------

// File: rtl/m_shiftseq.sv
// -----------------------------------------------------------------------------
// m_shiftseq -- sequencer for a bit-serial 32-bit shifter.
//
// Latches an operand and a shift opcode on an accepted start, asks the
// external shift counter to load its count, then shifts the result register
// one bit per cycle until the counter reports zero, and finally pulses done.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rstn       in   1   asynchronous active-low reset
//   start      in   1   request one shift operation (honoured in IDLE only)
//   op         in   2   00 SLL, 01 SRL, 11 SRA, 10 reserved (acts as SRL)
//   byteop     in   1   byte-lane shift request (used only with the macro below)
//   A          in  32   operand, sampled with start
//   lastshift  in   1   shift counter at zero (valid while s_shift[1]=1)
//   s_shift    out  2   counter op: 00 load B, 01 load B[1:0]*8, 10 down, 11 hold
//   Q          out 32   shift result register
//   busy       out  1   operation in progress
//   done       out  1   one-cycle pulse, Q valid
//
// Configuration
//   SHIFTSEQ_BYTESTEP_EN  defined: byteop is latched with start and, when set,
//                         LOAD asks the counter for B[1:0]*8 (s_shift=01).
//                         undefined: byteop is ignored, LOAD always uses 00.
// -----------------------------------------------------------------------------
module m_shiftseq (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic        byteop,
   input  logic [31:0] A,
   input  logic        lastshift,
   output logic [1:0]  s_shift,
   output logic [31:0] Q,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] CNT_LOAD_B    = 2'b00;
   localparam logic [1:0] CNT_LOAD_BYTE = 2'b01;
   localparam logic [1:0] CNT_DOWN      = 2'b10;
   localparam logic [1:0] CNT_HOLD      = 2'b11;

   state_t      state_q, state_d;
   logic [31:0] q_q, q_d;
   logic [1:0]  op_q, op_d;
   logic        load_byte_s;

   // One shift step; the reserved opcode 10 falls through to SRL.
   function automatic logic [31:0] shift_step(input logic [31:0] val,
                                              input logic [1:0]  code);
      logic [31:0] res;
      case (code)
         2'b00:   res = {val[30:0], 1'b0};
         2'b11:   res = {val[31], val[31:1]};
         default: res = {1'b0, val[31:1]};
      endcase
      return res;
   endfunction

`ifdef SHIFTSEQ_BYTESTEP_EN
   logic byteop_q, byteop_d;

   // Byte-lane request captured alongside the operand.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         byteop_q <= 1'b0;
      end else begin
         byteop_q <= byteop_d;
      end
   end

   // Only an accepted start may change the stored byte-lane request.
   always_comb begin
      byteop_d = byteop_q;
      if ((state_q == ST_IDLE) && start) begin
         byteop_d = byteop;
      end else begin
         byteop_d = byteop_q;
      end
   end

   assign load_byte_s = byteop_q;
`else
   logic unused_byteop_s;

   assign unused_byteop_s = byteop;
   assign load_byte_s     = 1'b0;
`endif

   // State, result and opcode registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         q_q     <= 32'h0000_0000;
         op_q    <= 2'b00;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         op_q    <= op_d;
      end
   end

   // Next-state logic; lastshift is only looked at in SHIFT.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD:  state_d = ST_SHIFT;
         ST_SHIFT: begin
            if (lastshift) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Datapath: capture operand on accepted start, step while counter nonzero.
   always_comb begin
      q_d  = q_q;
      op_d = op_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               q_d  = A;
               op_d = op;
            end else begin
               q_d  = q_q;
               op_d = op_q;
            end
         end
         ST_SHIFT: begin
            if (!lastshift) begin
               q_d = shift_step(q_q, op_q);
            end else begin
               q_d = q_q;
            end
         end
         default: begin
            q_d  = q_q;
            op_d = op_q;
         end
      endcase
   end

   // Moore outputs decoded from the state register.
   always_comb begin
      s_shift = CNT_HOLD;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            s_shift = CNT_HOLD;
         end
         ST_LOAD: begin
            s_shift = load_byte_s ? CNT_LOAD_BYTE : CNT_LOAD_B;
            busy    = 1'b1;
         end
         ST_SHIFT: begin
            s_shift = CNT_DOWN;
            busy    = 1'b1;
         end
         ST_DONE: begin
            s_shift = CNT_HOLD;
            done    = 1'b1;
         end
         default: begin
            s_shift = CNT_HOLD;
         end
      endcase
   end

   assign Q = q_q;

endmodule
